// File: rtl/param_fifo_if.sv
`default_nettype none
// =============================================================================
// Module   : param_fifo_if
// Brief    : Handshake/status bundle between a FIFO user and param_fifo.
// Revision : 1.0 - initial release
// =============================================================================
interface param_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write;
    logic                  read;
    logic                  flush;
    logic                  clear_errors;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data_in, write, read, flush, clear_errors,
        input  data_out, data_out_valid, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );

    modport slave (
        input  data_in, write, read, flush, clear_errors,
        output data_out, data_out_valid, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// =============================================================================
// Module   : param_fifo
// Brief    : Single-clock FIFO, registered read data, sticky error flags.
// Revision : 1.0 - initial release
// =============================================================================
module param_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    param_fifo_if.slave  bus
);
    localparam int                  C_DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH_W  = (ADDR_WIDTH+1)'(C_DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AF_W     = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AE_W     = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_out_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_do_read;
    logic w_do_write;
    logic w_ovf_evt;
    logic w_udf_evt;

    assign w_full  = (r_count == C_DEPTH_W);
    assign w_empty = (r_count == '0);

    // A read frees a slot on the same edge, so a full FIFO may still accept a write.
    assign w_do_read  = ~bus.flush & bus.read & ~w_empty;
    assign w_do_write = ~bus.flush & bus.write & (~w_full | w_do_read);
    assign w_ovf_evt  = ~bus.flush & bus.write & ~w_do_write;
    assign w_udf_evt  = ~bus.flush & bus.read & ~w_do_read;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_overflow       <= 1'b0;
            r_underflow      <= 1'b0;
        end else begin
            r_data_out_valid <= 1'b0;
            // A fresh error on the clearing edge wins over the clear.
            r_overflow       <= (r_overflow  & ~bus.clear_errors) | w_ovf_evt;
            r_underflow      <= (r_underflow & ~bus.clear_errors) | w_udf_evt;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_write) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_do_read) begin
                    r_rd_ptr         <= r_rd_ptr + 1'b1;
                    r_data_out       <= r_mem[r_rd_ptr];
                    r_data_out_valid <= 1'b1;
                end
                case ({w_do_write, w_do_read})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.data_out       = r_data_out;
    assign bus.data_out_valid = r_data_out_valid;
    assign bus.full           = w_full;
    assign bus.empty          = w_empty;
    assign bus.almost_full    = (r_count >= C_AF_W);
    assign bus.almost_empty   = (r_count <= C_AE_W);
    assign bus.count          = r_count;
    assign bus.overflow       = r_overflow;
    assign bus.underflow      = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// =============================================================================
// Module   : tb_param_fifo
// Brief    : Directed self-checking bench for param_fifo (default parameters).
// Revision : 1.0 - initial release
// =============================================================================
module tb_param_fifo;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    param_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    param_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write = 1'b0; bus.read = 1'b0; bus.flush = 1'b0; bus.clear_errors = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.data_in = '0;
        idle();
        bus.write = 1'b1;
        bus.read  = 1'b1;
        tick(); tick();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ae", bus.almost_empty, 1);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_dv", bus.data_out_valid, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_udf", bus.underflow, 0);
        idle();
        rst = 1'b0;
        tick();

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus.data_in = i; bus.write = 1'b1;
            tick();
            chk("fill_count", bus.count, i + 1);
            chk("fill_af", bus.almost_full, (i + 1) >= 14);
            chk("fill_ae", bus.almost_empty, (i + 1) <= 2);
        end
        chk("fill_full", bus.full, 1);
        bus.data_in = 32'h99;
        tick();
        chk("ovf_set", bus.overflow, 1);
        chk("ovf_count", bus.count, 16);
        idle(); bus.clear_errors = 1'b1;
        tick();
        chk("ovf_clr", bus.overflow, 0);

        // Drain in order
        idle(); bus.read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_data", bus.data_out, i);
            chk("drain_dv", bus.data_out_valid, 1);
        end
        idle();
        tick();
        chk("drain_dv_low", bus.data_out_valid, 0);
        chk("drain_empty", bus.empty, 1);
        bus.read = 1'b1;
        tick();
        chk("udf_set", bus.underflow, 1);
        chk("udf_dv", bus.data_out_valid, 0);
        chk("udf_dout", bus.data_out, 32'h0F);
        bus.clear_errors = 1'b1;
        tick();
        chk("udf_clr_collide", bus.underflow, 1);
        idle(); bus.clear_errors = 1'b1;
        tick();
        chk("udf_clr", bus.underflow, 0);

        // Wrap: hold count at 3 while streaming 40 words
        idle(); bus.write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 100 + i;
            tick();
        end
        bus.read = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.data_in = 103 + k;
            tick();
            chk("wrap_data", bus.data_out, 100 + k);
            chk("wrap_count", bus.count, 3);
        end
        bus.write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wrap_tail", bus.data_out, 140 + k);
        end
        idle();
        tick();
        chk("wrap_ovf", bus.overflow, 0);
        chk("wrap_udf", bus.underflow, 0);
        chk("wrap_empty", bus.empty, 1);

        // Full with simultaneous read and write
        bus.write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.data_in = 32'h200 + i;
            tick();
        end
        bus.data_in = 32'hAA; bus.read = 1'b1;
        tick();
        chk("fullrw_count", bus.count, 16);
        chk("fullrw_ovf", bus.overflow, 0);
        chk("fullrw_data", bus.data_out, 32'h200);
        idle(); bus.read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("fullrw_drain", bus.data_out, (i == 15) ? 32'hAA : 32'h201 + i);
        end
        idle();
        tick();

        // Empty with simultaneous read and write: no bypass
        bus.data_in = 32'h55; bus.write = 1'b1; bus.read = 1'b1;
        tick();
        chk("emptyrw_count", bus.count, 1);
        chk("emptyrw_udf", bus.underflow, 1);
        chk("emptyrw_dv", bus.data_out_valid, 0);
        chk("emptyrw_dout", bus.data_out, 32'hAA);
        idle(); bus.read = 1'b1;
        tick();
        chk("emptyrw_read", bus.data_out, 32'h55);

        // Flush beats read/write and leaves sticky flags alone
        idle(); bus.write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.data_in = 32'h300 + i;
            tick();
        end
        chk("pre_flush_count", bus.count, 5);
        bus.data_in = 32'h777; bus.read = 1'b1; bus.flush = 1'b1;
        tick();
        chk("flush_count", bus.count, 0);
        chk("flush_empty", bus.empty, 1);
        chk("flush_dv", bus.data_out_valid, 0);
        chk("flush_dout", bus.data_out, 32'h55);
        chk("flush_udf", bus.underflow, 1);
        chk("flush_ovf", bus.overflow, 0);
        idle(); bus.data_in = 32'h400; bus.write = 1'b1;
        tick();
        idle(); bus.read = 1'b1;
        tick();
        chk("post_flush_data", bus.data_out, 32'h400);
        chk("post_flush_dv", bus.data_out_valid, 1);
        idle(); bus.clear_errors = 1'b1;
        tick();
        chk("post_flush_clr", bus.underflow, 0);

        // Async reset mid-burst with count 7 and overflow set
        idle(); bus.write = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.data_in = 32'h500 + i;
            tick();
        end
        chk("ar_ovf_set", bus.overflow, 1);
        idle(); bus.read = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("ar_count7", bus.count, 7);
        chk("ar_dout", bus.data_out, 32'h508);
        idle(); bus.write = 1'b1; bus.data_in = 32'h600;
        #3 rst = 1'b1;
        #1;
        chk("ar_count", bus.count, 0);
        chk("ar_ovf", bus.overflow, 0);
        chk("ar_dout0", bus.data_out, 0);
        chk("ar_empty", bus.empty, 1);
        chk("ar_ae", bus.almost_empty, 1);
        bus.read = 1'b1; bus.flush = 1'b1;
        tick();
        chk("ar_hold_count", bus.count, 0);
        idle();
        rst = 1'b0;
        bus.read = 1'b1;
        tick();
        chk("ar_post_udf", bus.underflow, 1);
        chk("ar_post_dv", bus.data_out_valid, 0);
        chk("ar_post_dout", bus.data_out, 0);
        idle(); bus.clear_errors = 1'b1;
        tick();
        chk("ar_clr", bus.underflow, 0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter ADDR_WIDTH, default 4, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 16).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  DATA_WIDTH  write data.
REQ-008 write  input  1  write request, sampled on CLK rising edge.
REQ-009 read  input  1  read request, sampled on CLK rising edge.
REQ-010 flush  input  1  synchronous clear of stored contents.
REQ-011 clear_errors  input  1  synchronous clear of sticky error flags.
REQ-012 data_out  output  DATA_WIDTH  registered read data.
REQ-013 data_out_valid  output  1  high for one cycle when data_out holds a newly popped word.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 almost_full  output  1  count >= AF_LEVEL.
REQ-017 almost_empty  output  1  count <= AE_LEVEL.
REQ-018 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-019 overflow  output  1  sticky: write refused.
REQ-020 underflow  output  1  sticky: read refused.

Function
REQ-021 Storage SHALL be DEPTH x DATA_WIDTH; all DEPTH entries SHALL be usable (no sacrificed slot).
REQ-022 Read and write pointers SHALL be ADDR_WIDTH bits and wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-023 full, empty, almost_full, almost_empty SHALL be combinational decodes of registered count.
REQ-024 Accepted write: write=1 and (full=0 or accepted read same edge); stores data_in at wr_ptr, wr_ptr+1.
REQ-025 Accepted read: read=1 and empty=0; data_out <= mem[rd_ptr], rd_ptr+1, data_out_valid=1 next cycle.
REQ-026 Read latency SHALL be exactly 1 cycle; data_out SHALL hold its value when no read is accepted.
REQ-027 data_out_valid SHALL be 0 in any cycle following an edge with no accepted read.
REQ-028 count update per edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-029 Simultaneous read+write when full: both accepted, count stays DEPTH, overflow not set.
REQ-030 Simultaneous read+write when empty: read refused (underflow set), write accepted, count -> 1; no write-through bypass.
REQ-031 write=1 when full without accepted read: data discarded, pointers unchanged, overflow <= 1.
REQ-032 read=1 when empty: pointers and data_out unchanged, data_out_valid=0, underflow <= 1.
REQ-033 flush=1 SHALL take priority over read/write: pointers and count -> 0, data_out_valid -> 0, data_out held, memory contents not cleared.
REQ-034 overflow/underflow SHALL stay set until clear_errors=1 or RESET; a new error in the same edge as clear_errors SHALL leave the flag set.
REQ-035 flush SHALL not affect overflow/underflow.

Reset
REQ-036 RESET=1 SHALL immediately (no clock) force pointers=0, count=0, data_out=0, data_out_valid=0, overflow=0, underflow=0.
REQ-037 During RESET: empty=1, full=0, almost_empty=1, almost_full=0; read/write/flush ignored.
REQ-038 Reset mid-operation SHALL discard all stored words; first read after release with no writes SHALL be an underflow.
REQ-039 Memory array need not be reset.

Verification
REQ-040 Reset then write 0x00..0x0F (16 words, default params) -> full=1, count=16, almost_full=1 from count 14; 17th write -> overflow=1, count 16.
REQ-041 Read 16 words after REQ-040 -> data_out 0x00..0x0F in order, each one cycle after read, data_out_valid pulse each; then empty=1, extra read -> underflow=1, data_out stays 0x0F.
REQ-042 Pointer wrap: write/read 40 words interleaved with count held at 3 -> data order preserved across wrap, no error flags.
REQ-043 Full + simultaneous read/write of 0xAA -> count stays 16, overflow=0; 0xAA emerges as 16th word read afterward.
REQ-044 Write 5 words, assert flush with read=1 and write=1 -> count=0, empty=1, data_out_valid=0, error flags unchanged; next write/read returns new data.
REQ-045 Assert RESET asynchronously mid-burst (count=7, overflow=1) -> outputs take reset values before next CLK edge; clear_errors alone later clears sticky flags in one cycle.
